// File: rtl/register_file_clr_if.sv
// Register-file bus bundle: two read ports, one write port and the Busy flag.
// The master side drives indices and write data; the slave side returns operand data.
interface register_file_clr_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] RA;
    logic [ADDR_WIDTH-1:0] RB;
    logic [ADDR_WIDTH-1:0] RW;
    logic [DATA_WIDTH-1:0] BusW;
    logic                  RegWr;
    logic [DATA_WIDTH-1:0] BusA;
    logic [DATA_WIDTH-1:0] BusB;
    logic                  Busy;

    modport master (
        output RA, RB, RW, BusW, RegWr,
        input  BusA, BusB, Busy
    );

    modport slave (
        input  RA, RB, RW, BusW, RegWr,
        output BusA, BusB, Busy
    );
endinterface

// File: rtl/register_file_clr.sv
// LEGv8 register file with XZR, same-cycle write bypass and a post-reset
// clear engine that zeroes one entry per clock while Busy holds the datapath off.
module register_file_clr_rdport #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 31
) (
    input  logic [ADDR_WIDTH-1:0] rdAddr,
    input  logic                  busy,
    input  logic                  regWr,
    input  logic [ADDR_WIDTH-1:0] wrAddr,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic [DATA_WIDTH-1:0] arrData,
    output logic [DATA_WIDTH-1:0] rdData
);
    localparam logic [ADDR_WIDTH-1:0] ZeroIdx = ADDR_WIDTH'(ZERO_REG);

    // XZR and Busy win over the bypass, so a write aimed at XZR never leaks out.
    always_comb begin
        rdData = '0;
        if (busy || rdAddr == ZeroIdx)
            rdData = '0;
        else if (regWr && wrAddr == rdAddr)
            rdData = wrData;
        else
            rdData = arrData;
    end
endmodule

module register_file_clr #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 31
) (
    input  logic                Clk,
    input  logic                ResetL,
    register_file_clr_if.slave  rf
);
    localparam int NUM_REGS  = 1 << ADDR_WIDTH;
    localparam int NUM_PORTS = 2;
    localparam logic [ADDR_WIDTH-1:0] ZeroIdx = ADDR_WIDTH'(ZERO_REG);
    localparam logic [ADDR_WIDTH-1:0] LastClr = ADDR_WIDTH'(ZERO_REG - 1);

    typedef enum logic [0:0] {
        StClear = 1'b0,
        StRun   = 1'b1
    } stateE;

    stateE                  stateQ, stateD;
    logic [ADDR_WIDTH-1:0]  clrPtrQ, clrPtrD;
    logic                   clrWe;
    logic                   wrEn;
    logic                   busy;

    logic [DATA_WIDTH-1:0]  regFile [NUM_REGS];

    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] rdAddr;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] arrData;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdData;

    always_ff @(posedge Clk) begin
        if (!ResetL) begin
            stateQ  <= StClear;
            clrPtrQ <= '0;
        end else begin
            stateQ  <= stateD;
            clrPtrQ <= clrPtrD;
        end
    end

    // Clear walks 0..ZERO_REG-1; XZR itself is never stored, so the pointer never wraps.
    always_comb begin
        stateD  = stateQ;
        clrPtrD = clrPtrQ;
        clrWe   = 1'b0;
        case (stateQ)
            StClear: begin
                clrWe   = 1'b1;
                clrPtrD = clrPtrQ + ADDR_WIDTH'(1);
                if (clrPtrQ == LastClr)
                    stateD = StRun;
            end
            StRun: begin
                stateD = StRun;
            end
            default: begin
                stateD = StClear;
            end
        endcase
    end

    assign busy = !ResetL || (stateQ != StRun);
    assign wrEn = (stateQ == StRun) && rf.RegWr && (rf.RW != ZeroIdx);

    always_ff @(posedge Clk) begin
        if (ResetL) begin
            if (clrWe)
                regFile[clrPtrQ] <= '0;
            else if (wrEn)
                regFile[rf.RW] <= rf.BusW;
        end
    end

    assign rdAddr[0] = rf.RA;
    assign rdAddr[1] = rf.RB;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : gPort
        assign arrData[p] = regFile[rdAddr[p]];

        register_file_clr_rdport #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .ZERO_REG   (ZERO_REG)
        ) uPort (
            .rdAddr  (rdAddr[p]),
            .busy    (busy),
            .regWr   (rf.RegWr),
            .wrAddr  (rf.RW),
            .wrData  (rf.BusW),
            .arrData (arrData[p]),
            .rdData  (rdData[p])
        );
    end

    assign rf.BusA = rdData[0];
    assign rf.BusB = rdData[1];
    assign rf.Busy = busy;
endmodule
